// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read-side stream adapter.
package fifo_pkg;

    localparam int unsigned DATA_WIDTH = 8;
    localparam int unsigned BEAT_W     = 16;

    typedef logic [DATA_WIDTH-1:0] fifo_word_t;

endpackage

// File: rtl/stream_skid_buf.sv
// Two-entry in-order register buffer; entry0 is always the head word.
module stream_skid_buf
    import fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DATA_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [1:0]       count,
    output logic [WIDTH-1:0] head
);

    logic [WIDTH-1:0] entry0_q, entry0_d;
    logic [WIDTH-1:0] entry1_q, entry1_d;
    logic [1:0]       count_q, count_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            entry0_q <= '0;
            entry1_q <= '0;
            count_q  <= 2'd0;
        end else begin
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10: begin
                if (count_q == 2'd0) begin
                    entry0_d = push_data;
                end else begin
                    entry1_d = push_data;
                end
                count_d = count_q + 2'd1;
            end
            2'b01: begin
                entry0_d = entry1_q;
                count_d  = count_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous push/pop: the new word lands behind whatever remains.
                if (count_q == 2'd1) begin
                    entry0_d = push_data;
                end else begin
                    entry0_d = entry1_q;
                    entry1_d = push_data;
                end
            end
            default: ;
        endcase
    end

    assign count = count_q;
    assign head  = entry0_q;

endmodule

// File: rtl/fifo_stream_reader.sv
// Pops a synchronous FIFO (1-cycle read latency) and presents the words as a
// valid/ready stream with packet framing via a beat counter.
module fifo_stream_reader
    import fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = fifo_pkg::DATA_WIDTH,
    parameter int unsigned PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    output logic                  fifo_rd_en,
    input  logic [DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                  fifo_empty,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    input  logic                  m_ready,
    output logic [BEAT_W-1:0]     beat_cnt
);

    localparam logic [BEAT_W-1:0] LastBeat = BEAT_W'(PKT_LEN - 1);

    logic [1:0]        buf_cnt;
    logic              inflight_q, inflight_d;
    logic              pop;
    logic [2:0]        occupancy;
    logic [BEAT_W-1:0] beat_cnt_q, beat_cnt_d;

    assign pop = m_valid && m_ready;

    // Slots committed after this edge; pop implies buf_cnt >= 1, so no underflow.
    assign occupancy  = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
    assign fifo_rd_en = enable && !fifo_empty && (occupancy < 3'd2);
    assign inflight_d = fifo_rd_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight_q <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            inflight_q <= inflight_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (pop) begin
            if (beat_cnt_q == LastBeat) begin
                beat_cnt_d = '0;
            end else begin
                beat_cnt_d = beat_cnt_q + 1'b1;
            end
        end
    end

    stream_skid_buf #(
        .WIDTH (DATA_WIDTH)
    ) u_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (inflight_q),
        .push_data (fifo_rd_data),
        .pop       (pop),
        .count     (buf_cnt),
        .head      (m_data)
    );

    assign m_valid  = (buf_cnt != 2'd0);
    assign m_last   = m_valid && (beat_cnt_q == LastBeat);
    assign beat_cnt = beat_cnt_q;

endmodule
